mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Ports SHALL be exactly these, one clock domain; reset asynchronous, active-low:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request, held until if_ready
- if_addr  in  16  fetch address
- if_rdata  out  16  fetch read data, valid while if_ready=1
- if_ready  out  1  one-cycle fetch completion pulse
- mem_read  in  1  data read request, held until mem_ready
- mem_write  in  1  data write request, held until mem_ready
- mem_addr  in  16  data address
- mem_wdata  in  16  data write value
- mem_rdata  out  16  data read value, valid while mem_ready=1
- mem_ready  out  1  one-cycle data completion pulse
- stall  out  1  pipeline freeze request
- ram_addr  out  16  SRAM address
- ram_wdata  out  16  SRAM write data
- ram_rdata  in  16  SRAM read data
- ram_data_oe  out  1  1 = drive ram_wdata onto the SRAM bus
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low

Function
REQ-002 The FSM SHALL have states IDLE, RD, WSETUP, WPULSE, WHOLD.
REQ-003 In IDLE, a data request SHALL win over if_req; fetch is granted only when mem_read=mem_write=0.
REQ-004 If mem_read and mem_write are both 1, the write SHALL win.
REQ-005 A requester whose ready is 1 in the current cycle SHALL be masked from arbitration in that cycle.
REQ-006 On grant, the arbiter SHALL latch address, write data and requester ID; the next state is RD for a read and WSETUP for a write.
REQ-007 RD SHALL last 1 cycle with ce_n=0 and oe_n=0.
- At the end of RD, ram_rdata SHALL be registered.
- The next cycle SHALL be IDLE with the matching ready=1 and rdata valid.
- Read latency is 2 cycles, grant edge to ready.
REQ-008 The write sequence SHALL be:
- WSETUP: ce_n=0, we_n=1, data_oe=1.
- WPULSE: we_n=0.
- WHOLD: we_n=1, data_oe=1.
- Then IDLE with mem_ready=1.
- Write latency is 4 cycles.
REQ-009 ram_addr and ram_wdata SHALL be stable from WSETUP through WHOLD.
REQ-010 ram_we_n=0 SHALL never coincide with ram_oe_n=0.
REQ-011 In IDLE without grant, all strobes SHALL be 1 and data_oe=0.
REQ-012 if_ready and mem_ready SHALL be registered, never both 1 in the same cycle.
REQ-013 stall SHALL be 1 whenever (if_req & ~if_ready) | ((mem_read|mem_write) & ~mem_ready).
REQ-014 if_rdata and mem_rdata SHALL hold their last value until the next completion to that requester.
REQ-015 A new grant SHALL be possible in the same IDLE cycle that presents a ready, for the other requester only.

Reset
REQ-016 On rst=0, asynchronously: state=IDLE; ce_n=oe_n=we_n=1; data_oe=0; both readies=0; stall follows REQ-013 with readies=0; rdata registers=0; ram_addr=0.
REQ-017 Reset mid-write SHALL force we_n=1 immediately; the partial write is not retried.
REQ-018 After rst releases, the first grant SHALL occur on the first rising edge with a request.

Structure
REQ-019 State encodings, requester IDs and write-phase cycle counts SHALL live in the shared config header.
REQ-020 One sub-module, sram_phy, SHALL be natural: it registers strobes, address and data from FSM phase outputs.
REQ-021 Estimated implementation size: 150-250 lines.

Verification
REQ-022 if_req=1, if_addr=0x0040, SRAM[0x0040]=0x4C01 -> if_ready pulse 2 cycles after grant, if_rdata=0x4C01.
REQ-023 mem_write=1, addr=0x8000, wdata=0xBEEF -> we_n low exactly 1 cycle inside data_oe window; mem_ready after 4 cycles; a later read returns 0xBEEF.
REQ-024 if_req and mem_read=1 same cycle -> data granted first; fetch granted in the mem_ready cycle; stall=1 until if_ready.
REQ-025 mem_read=mem_write=1 -> write sequence executed, no RD state entered.
REQ-026 rst=0 during WPULSE -> we_n=1 same cycle (asynchronous), state IDLE, no ready pulse; normal grant on the first edge after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared configuration for the instruction/data SRAM arbiter: state encodings,
// requester IDs, write-phase lengths and the per-phase SRAM strobe decode.
package mem_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Write phase lengths in clock cycles; CNT_W must hold the largest minus one.
    localparam int WSETUP_CYCLES = 1;
    localparam int WPULSE_CYCLES = 1;
    localparam int WHOLD_CYCLES  = 1;
    localparam int CNT_W         = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WSETUP = 3'd2,
        S_WPULSE = 3'd3,
        S_WHOLD  = 3'd4
    } state_t;

    typedef enum logic {
        ID_IF  = 1'b0,
        ID_MEM = 1'b1
    } req_id_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic data_oe;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, data_oe: 1'b0};

    // Strobe pattern the SRAM pins must show while the FSM sits in state s.
    function automatic strobe_t phase_strobes(input state_t s);
        strobe_t st;
        st = STROBE_IDLE;
        case (s)
            S_RD: begin
                st.ce_n = 1'b0;
                st.oe_n = 1'b0;
            end
            S_WSETUP, S_WHOLD: begin
                st.ce_n    = 1'b0;
                st.data_oe = 1'b1;
            end
            S_WPULSE: begin
                st.ce_n    = 1'b0;
                st.we_n    = 1'b0;
                st.data_oe = 1'b1;
            end
            default: st = STROBE_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mem_arbiter_sram_phy.sv
// SRAM pin stage: registers address, write data and strobes so the pins change
// only on clock edges and line up with the arbiter state they belong to.
module mem_arbiter_sram_phy
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  strobe_t           strobe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_data_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    // Address and data load only on grant, so they stay put for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (load) begin
            ram_addr  <= addr;
            ram_wdata <= wdata;
        end
    end

    // Reset pulls we_n high immediately, cutting any write pulse in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_data_oe <= 1'b0;
        end else begin
            ram_ce_n    <= strobe.ce_n;
            ram_oe_n    <= strobe.oe_n;
            ram_we_n    <= strobe.we_n;
            ram_data_oe <= strobe.data_oe;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one asynchronous SRAM; the data
// port has priority, reads take 2 cycles grant-to-ready and writes take 4.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_data_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    state_t            state, state_nxt;
    req_id_t           id, id_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              load;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    strobe_t           strobe_nxt;
    logic              if_pend, mem_pend;

    // A requester showing ready this cycle is still holding its old request.
    assign if_pend  = if_req & ~if_ready;
    assign mem_pend = (mem_read | mem_write) & ~mem_ready;
    assign stall    = if_pend | mem_pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            id    <= ID_IF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            id    <= id_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id;
        cnt_nxt   = cnt;
        load      = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        case (state)
            S_IDLE: begin
                if (mem_pend) begin
                    load      = 1'b1;
                    id_nxt    = ID_MEM;
                    state_nxt = mem_write ? S_WSETUP : S_RD;
                end else if (if_pend) begin
                    load      = 1'b1;
                    id_nxt    = ID_IF;
                    addr_nxt  = if_addr;
                    state_nxt = S_RD;
                end
            end
            S_RD: state_nxt = S_IDLE;
            S_WSETUP: begin
                if (cnt == CNT_W'(WSETUP_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WPULSE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WPULSE: begin
                if (cnt == CNT_W'(WPULSE_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WHOLD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WHOLD: begin
                if (cnt == CNT_W'(WHOLD_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
        strobe_nxt = phase_strobes(state_nxt);
    end

    // Completion stage: readies and read data land the cycle after RD/WHOLD ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_ready  <= (state == S_RD) && (id == ID_IF);
            mem_ready <= ((state == S_RD) && (id == ID_MEM)) ||
                         ((state == S_WHOLD) && (state_nxt == S_IDLE));
            if (state == S_RD && id == ID_IF)
                if_rdata <= ram_rdata;
            if (state == S_RD && id == ID_MEM)
                mem_rdata <= ram_rdata;
        end
    end

    mem_arbiter_sram_phy sram_phy (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .addr        (addr_nxt),
        .wdata       (wdata_nxt),
        .strobe      (strobe_nxt),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_data_oe (ram_data_oe),
        .ram_ce_n    (ram_ce_n),
        .ram_oe_n    (ram_oe_n),
        .ram_we_n    (ram_we_n)
    );

endmodule
